// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache/memory block-transfer arbiter.
package cache_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_BEATS  = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CMD   = 3'd1,
      ST_WDATA = 3'd2,
      ST_WRESP = 3'd3,
      ST_RDATA = 3'd4
   } arb_state_t;

endpackage : cache_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that was not granted last wins.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule : rr_arbiter2

// File: rtl/cache_mem_arbiter.sv
// Arbitrates I-side and D-side block transfers onto one burst memory port,
// one transfer in flight at a time.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no transfer; grant a requester and latch its rw/addr
// ST_CMD   | burst command presented until mem_cmd_ready
// ST_WDATA | streaming owner's write beats, wlast on the final one
// ST_WRESP | all beats sent, waiting for mem_bvalid
// ST_RDATA | forwarding read beats to the owner, done with the final one
module cache_mem_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int BEATS  = DEF_BEATS
) (
   input  logic                   clk,
   input  logic                   rst_n,

   input  logic [1:0]             req_valid,
   input  logic [1:0]             req_rw,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   output logic [1:0]             req_ack,
   output logic [1:0]             req_done,
   input  logic [1:0][DATA_W-1:0] wr_data,
   output logic [1:0]             wr_pop,
   output logic [DATA_W-1:0]      rd_data,
   output logic [1:0]             rd_valid,

   output logic                   mem_cmd_valid,
   input  logic                   mem_cmd_ready,
   output logic                   mem_cmd_rw,
   output logic [ADDR_W-1:0]      mem_cmd_addr,

   output logic [DATA_W-1:0]      mem_wdata,
   output logic                   mem_wvalid,
   input  logic                   mem_wready,
   output logic                   mem_wlast,
   input  logic                   mem_bvalid,

   input  logic [DATA_W-1:0]      mem_rdata,
   input  logic                   mem_rvalid,
   output logic                   mem_rready
);

   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   arb_state_t        state_q, state_d;
   logic              owner_q, owner_d;
   logic              rw_q, rw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_q, last_d;
   logic [1:0]        gnt;
   logic              at_last;

   rr_arbiter2 u_rr (
      .req  (req_valid),
      .last (last_q),
      .gnt  (gnt)
   );

   assign at_last = (cnt_q == LAST_BEAT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      owner_d       = owner_q;
      rw_d          = rw_q;
      addr_d        = addr_q;
      cnt_d         = cnt_q;
      last_d        = last_q;
      req_ack       = 2'b00;
      req_done      = 2'b00;
      wr_pop        = 2'b00;
      rd_data       = '0;
      rd_valid      = 2'b00;
      mem_cmd_valid = 1'b0;
      mem_cmd_rw    = 1'b0;
      mem_cmd_addr  = '0;
      mem_wdata     = '0;
      mem_wvalid    = 1'b0;
      mem_wlast     = 1'b0;
      mem_rready    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|gnt) begin
               req_ack = gnt;
               owner_d = gnt[1];
               last_d  = gnt[1];
               rw_d    = req_rw[gnt[1]];
               addr_d  = req_addr[gnt[1]];
               cnt_d   = '0;
               state_d = ST_CMD;
            end
         end

         ST_CMD: begin
            mem_cmd_valid = 1'b1;
            mem_cmd_rw    = rw_q;
            mem_cmd_addr  = addr_q;
            if (mem_cmd_ready) begin
               state_d = rw_q ? ST_WDATA : ST_RDATA;
            end
         end

         ST_WDATA: begin
            mem_wvalid = 1'b1;
            mem_wdata  = wr_data[owner_q];
            mem_wlast  = at_last;
            if (mem_wready) begin
               wr_pop[owner_q] = 1'b1;
               cnt_d           = cnt_q + 1'b1;
               if (at_last) begin
                  state_d = ST_WRESP;
               end
            end
         end

         ST_WRESP: begin
            if (mem_bvalid) begin
               req_done[owner_q] = 1'b1;
               state_d           = ST_IDLE;
            end
         end

         ST_RDATA: begin
            mem_rready = 1'b1;
            if (mem_rvalid) begin
               rd_data           = mem_rdata;
               rd_valid[owner_q] = 1'b1;
               cnt_d             = cnt_q + 1'b1;
               if (at_last) begin
                  req_done[owner_q] = 1'b1;
                  state_d           = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Outputs are combinational, so force them quiet while reset is held.
      if (!rst_n) begin
         req_ack       = 2'b00;
         req_done      = 2'b00;
         wr_pop        = 2'b00;
         rd_data       = '0;
         rd_valid      = 2'b00;
         mem_cmd_valid = 1'b0;
         mem_cmd_rw    = 1'b0;
         mem_cmd_addr  = '0;
         mem_wdata     = '0;
         mem_wvalid    = 1'b0;
         mem_wlast     = 1'b0;
         mem_rready    = 1'b0;
      end
   end

endmodule : cache_mem_arbiter

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized
// transfers checked against a transaction-level model of grant order and beats.
module tb_cache_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BEATS  = 16;

   logic                   clk;
   logic                   rst_n;
   logic [1:0]             req_valid;
   logic [1:0]             req_rw;
   logic [1:0][ADDR_W-1:0] req_addr;
   logic [1:0]             req_ack;
   logic [1:0]             req_done;
   logic [1:0][DATA_W-1:0] wr_data;
   logic [1:0]             wr_pop;
   logic [DATA_W-1:0]      rd_data;
   logic [1:0]             rd_valid;
   logic                   mem_cmd_valid;
   logic                   mem_cmd_ready;
   logic                   mem_cmd_rw;
   logic [ADDR_W-1:0]      mem_cmd_addr;
   logic [DATA_W-1:0]      mem_wdata;
   logic                   mem_wvalid;
   logic                   mem_wready;
   logic                   mem_wlast;
   logic                   mem_bvalid;
   logic [DATA_W-1:0]      mem_rdata;
   logic                   mem_rvalid;
   logic                   mem_rready;

   int total = 0;
   int bad   = 0;
   int last_w;

   logic any_out;
   assign any_out = |{req_ack, req_done, wr_pop, rd_data, rd_valid, mem_cmd_valid,
                      mem_cmd_rw, mem_cmd_addr, mem_wdata, mem_wvalid, mem_wlast,
                      mem_rready};

   cache_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_rw        (req_rw),
      .req_addr      (req_addr),
      .req_ack       (req_ack),
      .req_done      (req_done),
      .wr_data       (wr_data),
      .wr_pop        (wr_pop),
      .rd_data       (rd_data),
      .rd_valid      (rd_valid),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_ready (mem_cmd_ready),
      .mem_cmd_rw    (mem_cmd_rw),
      .mem_cmd_addr  (mem_cmd_addr),
      .mem_wdata     (mem_wdata),
      .mem_wvalid    (mem_wvalid),
      .mem_wready    (mem_wready),
      .mem_wlast     (mem_wlast),
      .mem_bvalid    (mem_bvalid),
      .mem_rdata     (mem_rdata),
      .mem_rvalid    (mem_rvalid),
      .mem_rready    (mem_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] onehot(input int w);
      return (w == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic quiet_inputs();
      req_valid     = 2'b00;
      req_rw        = 2'b00;
      mem_cmd_ready = 1'b0;
      mem_wready    = 1'b0;
      mem_bvalid    = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n         = 1'b0;
      req_valid     = 2'b11;
      mem_rvalid    = 1'b1;
      mem_bvalid    = 1'b1;
      mem_cmd_ready = 1'b1;
      mem_wready    = 1'b1;
      repeat (2) begin
         #1 chk("rst_outs", any_out, 0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      quiet_inputs();
      last_w = 1;
      #1 chk("post_rst_idle", any_out, 0);
   endtask

   task automatic idle_check();
      @(negedge clk);
      req_valid     = 2'b00;
      mem_rvalid    = 1'($urandom);
      mem_bvalid    = 1'($urandom);
      mem_cmd_ready = 1'($urandom);
      mem_wready    = 1'($urandom);
      #1 chk("idle_outs", any_out, 0);
   endtask

   // mode: 0 = memory always ready, 1 = random gaps, 2 = ready every other cycle
   task automatic do_xfer(input logic [1:0] v, input logic [1:0] rw,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input int stall, input int mode, input bit drop,
                          input bit stray, input int abort_beat);
      int          w;
      logic        exp_rw;
      logic [31:0] exp_addr;
      logic [31:0] wbuf [BEATS];
      logic [31:0] d;
      int          beat;
      int          cyc;
      bit          r;
      bit          aborted;

      w        = (v == 2'b11) ? ((last_w == 1) ? 0 : 1) : (v[1] ? 1 : 0);
      last_w   = w;
      exp_rw   = rw[w];
      exp_addr = (w == 1) ? a1 : a0;
      for (int i = 0; i < BEATS; i++) wbuf[i] = $urandom;
      aborted = 1'b0;

      @(negedge clk);
      req_valid     = v;
      req_rw        = rw;
      req_addr[0]   = a0;
      req_addr[1]   = a1;
      mem_rvalid    = stray;
      mem_bvalid    = stray;
      mem_cmd_ready = 1'b0;
      mem_wready    = 1'b0;
      #1;
      chk("ack", req_ack, onehot(w));
      chk("ack_rdv", rd_valid, 0);
      chk("ack_done", req_done, 0);

      for (int i = 0; i <= stall; i++) begin
         @(negedge clk);
         req_valid     = drop ? 2'b00 : v;
         req_rw        = 2'($urandom);
         req_addr[0]   = $urandom;
         req_addr[1]   = $urandom;
         mem_rvalid    = 1'($urandom);
         mem_bvalid    = 1'($urandom);
         mem_wready    = 1'($urandom);
         mem_cmd_ready = (i == stall);
         #1;
         chk("cmd_valid", mem_cmd_valid, 1);
         chk("cmd_rw", mem_cmd_rw, exp_rw);
         chk("cmd_addr", mem_cmd_addr, exp_addr);
         chk("cmd_quiet", {req_ack, req_done, wr_pop, rd_valid, mem_wvalid, mem_rready}, 0);
      end

      beat = 0;
      cyc  = 0;
      while (beat < BEATS && cyc < 400) begin
         @(negedge clk);
         cyc++;
         mem_cmd_ready = 1'($urandom);
         mem_bvalid    = 1'($urandom);
         req_valid     = drop ? 2'b00 : v;
         r = (mode == 0) ? 1'b1 : (mode == 2) ? ((cyc % 2) == 0) : 1'($urandom);
         if (!exp_rw) begin
            d          = $urandom;
            mem_rdata  = d;
            mem_rvalid = r;
            if (r && beat == abort_beat) rst_n = 1'b0;
            #1;
            if (!rst_n) begin
               chk("abort_outs", any_out, 0);
               aborted = 1'b1;
               break;
            end
            chk("rd_ready", mem_rready, 1);
            chk("rd_valid", rd_valid, r ? onehot(w) : 2'b00);
            if (r) chk("rd_data", rd_data, d);
            chk("rd_done", req_done, (r && beat == BEATS - 1) ? onehot(w) : 2'b00);
            chk("rd_ack", req_ack, 0);
            chk("rd_cmdv", mem_cmd_valid, 0);
         end else begin
            mem_wready   = r;
            mem_rvalid   = 1'($urandom);
            wr_data[w]   = wbuf[beat];
            wr_data[1-w] = $urandom;
            #1;
            chk("w_valid", mem_wvalid, 1);
            chk("w_data", mem_wdata, wbuf[beat]);
            chk("w_last", mem_wlast, (beat == BEATS - 1));
            chk("w_pop", wr_pop, r ? onehot(w) : 2'b00);
            chk("w_done", req_done, 0);
            chk("w_rdv", rd_valid, 0);
         end
         if (r) beat++;
      end
      if (cyc >= 400) chk("beat_timeout", 1, 0);

      if (aborted) begin
         @(negedge clk);
         rst_n = 1'b1;
         quiet_inputs();
         mem_rvalid = 1'b1;
         mem_bvalid = 1'b1;
         #1 chk("abort_idle", any_out, 0);
         last_w = 1;
         return;
      end

      if (exp_rw) begin
         int k;
         k = $urandom_range(0, 3);
         for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            mem_wready = 1'b1;
            mem_rvalid = 1'($urandom);
            mem_bvalid = (i == k);
            req_valid  = drop ? 2'b00 : v;
            #1;
            chk("wr_resp_done", req_done, (i == k) ? onehot(w) : 2'b00);
            chk("wr_resp_quiet", {req_ack, wr_pop, mem_wvalid, rd_valid}, 0);
         end
      end

      @(negedge clk);
      quiet_inputs();
   endtask

   initial begin
      rst_n    = 1'b0;
      req_addr = '0;
      wr_data  = '0;
      quiet_inputs();
      last_w   = 1;

      do_reset();
      do_xfer(2'b01, 2'b00, 32'h100, 32'h0, 0, 0, 1'b0, 1'b0, -1);
      idle_check();

      do_reset();
      do_xfer(2'b11, 2'b00, 32'h200, 32'h300, 0, 1, 1'b0, 1'b0, -1);
      do_xfer(2'b11, 2'b00, 32'h240, 32'h340, 0, 1, 1'b0, 1'b0, -1);

      do_xfer(2'b10, 2'b10, 32'h0, 32'h8000, 0, 2, 1'b0, 1'b0, -1);
      idle_check();
      do_xfer(2'b01, 2'b01, 32'h4440, 32'h0, 5, 1, 1'b0, 1'b0, -1);
      do_xfer(2'b10, 2'b00, 32'h0, 32'hABC0, 2, 1, 1'b1, 1'b1, -1);

      do_xfer(2'b01, 2'b00, 32'h1000, 32'h0, 0, 0, 1'b0, 1'b0, 7);
      do_xfer(2'b11, 2'b00, 32'h1040, 32'h2040, 0, 0, 1'b0, 1'b0, -1);

      for (int n = 0; n < 24; n++) begin
         do_xfer(2'($urandom_range(1, 3)), 2'($urandom),
                 $urandom & 32'hFFFF_FFC0, $urandom & 32'hFFFF_FFC0,
                 $urandom_range(0, 3), $urandom_range(0, 2),
                 1'($urandom), 1'($urandom), -1);
         if ($urandom_range(0, 1) == 1) idle_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cache_mem_arbiter
